// File: rtl/crc_frame_engine.sv
// Beat-parallel CRC frame engine: generate/check FCS over valid/ready beats, with length checking.
// Optional CRC_FRAME_REFLECT_EN: LSB-first beat processing and a bit-reversed result.
module crc_frame_engine #(
  parameter int          CRC_W     = 16,
  parameter logic [31:0] POLY      = 32'h1021,
  parameter logic [31:0] INIT      = 32'h0,
  parameter int          DATA_W    = 8,
  parameter int          MIN_BEATS = 5,
  parameter int          MAX_BEATS = 127,
  parameter logic [31:0] RESIDUE   = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              mode,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CRC_W-1:0]  crc,
  output logic              crc_ok,
  output logic              len_error
);

  localparam int CNT_W = $clog2(MAX_BEATS + 2);
  localparam logic [CRC_W-1:0] POLY_C = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] INIT_C = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] RES_C  = RESIDUE[CRC_W-1:0];
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_BEATS);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] SAT_C  = CNT_W'(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CRC_W-1:0]   crc_reg_q, crc_reg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [CRC_W-1:0]   res_crc_q, res_crc_d;
  logic               res_ok_q, res_ok_d;
  logic               res_lerr_q, res_lerr_d;
  logic               rdy_en_q;

  logic               beat;
  logic               mode_cur;
  logic               lerr_new;
  logic [CRC_W-1:0]   crc_upd;
  logic [CRC_W-1:0]   crc_fin;
  logic [CNT_W-1:0]   cnt_inc;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] r;
    logic             b;
    r = c;
    for (int i = 0; i < DATA_W; i++) begin
`ifdef CRC_FRAME_REFLECT_EN
      b = d[i];
`else
      b = d[DATA_W-1-i];
`endif
      r = {r[CRC_W-2:0], 1'b0} ^ ((r[CRC_W-1] ^ b) ? POLY_C : '0);
    end
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] out_map(input logic [CRC_W-1:0] c);
    logic [CRC_W-1:0] r;
`ifdef CRC_FRAME_REFLECT_EN
    for (int i = 0; i < CRC_W; i++) r[i] = c[CRC_W-1-i];
`else
    r = c;
`endif
    return r;
  endfunction

  assign s_ready   = rdy_en_q && (state_q != DONE);
  assign res_valid = (state_q == DONE);
  assign crc       = res_crc_q;
  assign crc_ok    = res_ok_q;
  assign len_error = res_lerr_q;

  // The first beat of a frame always starts from INIT and samples mode live.
  assign beat     = s_valid && s_ready;
  assign mode_cur = (state_q == IDLE) ? mode : mode_q;
  assign crc_upd  = crc_step((state_q == IDLE) ? INIT_C : crc_reg_q, s_data);
  assign crc_fin  = out_map(crc_upd);
  assign cnt_inc  = (state_q == IDLE) ? CNT_W'(1) :
                    (cnt_q == SAT_C)  ? cnt_q : cnt_q + CNT_W'(1);
  assign lerr_new = (cnt_inc < MIN_C) || (cnt_inc > MAX_C);

  always_comb begin
    state_d    = state_q;
    crc_reg_d  = crc_reg_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    res_crc_d  = res_crc_q;
    res_ok_d   = res_ok_q;
    res_lerr_d = res_lerr_q;
    case (state_q)
      IDLE, RUN: begin
        if (beat) begin
          crc_reg_d = crc_upd;
          cnt_d     = cnt_inc;
          mode_d    = mode_cur;
          state_d   = RUN;
          if (s_last) begin
            state_d    = DONE;
            res_crc_d  = lerr_new ? '0 : crc_fin;
            res_ok_d   = mode_cur && !lerr_new && (crc_fin == RES_C);
            res_lerr_d = lerr_new;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d   = IDLE;
          crc_reg_d = INIT_C;
          cnt_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d   = IDLE;
      crc_reg_d = INIT_C;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      crc_reg_q  <= INIT_C;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      res_crc_q  <= '0;
      res_ok_q   <= 1'b0;
      res_lerr_q <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_reg_q  <= crc_reg_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      res_crc_q  <= res_crc_d;
      res_ok_q   <= res_ok_d;
      res_lerr_q <= res_lerr_d;
      rdy_en_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_crc_frame_engine.sv
// Directed bench for crc_frame_engine at default parameters (8-bit beats, CRC-16 0x1021).
module tb_crc_frame_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        mode = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] crc;
  logic        crc_ok;
  logic        len_error;

  crc_frame_engine dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .crc(crc), .crc_ok(crc_ok), .len_error(len_error)
  );

  always #5 clk = ~clk;

`ifdef CRC_FRAME_REFLECT_EN
  localparam logic [15:0] STD_CRC = 16'h2189;
  localparam logic [7:0]  FCS0 = 8'h89;
  localparam logic [7:0]  FCS1 = 8'h21;
`else
  localparam logic [15:0] STD_CRC = 16'h31C3;
  localparam logic [7:0]  FCS0 = 8'h31;
  localparam logic [7:0]  FCS1 = 8'hC3;
`endif

  int n_err = 0;
  int n_chk = 0;
  logic [7:0] frm[$];
  logic [15:0] held_crc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_std();
    frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  endtask

  task automatic load_n(input int n);
    frm = {};
    for (int i = 0; i < n; i++) frm.push_back(8'(i * 37 + 5));
  endtask

  // Drives the queued frame one beat per clock; returns 1 ns after the s_last edge.
  task automatic send_frame(input logic m);
    for (int i = 0; i < frm.size(); i++) begin
      mode    = m;
      s_valid = 1'b1;
      s_data  = frm[i];
      s_last  = (i == frm.size() - 1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  function automatic logic [15:0] crc_model();
    logic [15:0] r;
    logic [15:0] o;
    logic        b;
    r = 16'h0000;
    foreach (frm[i]) begin
      for (int k = 0; k < 8; k++) begin
`ifdef CRC_FRAME_REFLECT_EN
        b = frm[i][k];
`else
        b = frm[i][7-k];
`endif
        if (r[15] ^ b) r = (r << 1) ^ 16'h1021;
        else           r = r << 1;
      end
    end
`ifdef CRC_FRAME_REFLECT_EN
    for (int k = 0; k < 16; k++) o[k] = r[15-k];
`else
    o = r;
`endif
    return o;
  endfunction

  initial begin
    #12;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_crc", 32'(crc), 32'd0);
    chk("rst_crc_ok", 32'(crc_ok), 32'd0);
    chk("rst_len_error", 32'(len_error), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_s_ready", 32'(s_ready), 32'd1);

    // Generate, then hold off the consumer for five cycles.
    load_std();
    send_frame(1'b0);
    chk("gen_res_valid", 32'(res_valid), 32'd1);
    chk("gen_crc", 32'(crc), 32'(STD_CRC));
    chk("gen_len_error", 32'(len_error), 32'd0);
    chk("gen_crc_ok", 32'(crc_ok), 32'd0);
    held_crc = crc;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 8'hAA;
      @(posedge clk); #1;
      chk("bp_s_ready", 32'(s_ready), 32'd0);
      chk("bp_res_valid", 32'(res_valid), 32'd1);
      chk("bp_crc", 32'(crc), 32'(held_crc));
    end
    s_valid = 1'b0;
    take_result();
    chk("take_res_valid", 32'(res_valid), 32'd0);
    chk("take_s_ready", 32'(s_ready), 32'd1);

    // Back-to-back check-mode frame with a good FCS.
    load_std();
    frm.push_back(FCS0); frm.push_back(FCS1);
    send_frame(1'b1);
    chk("chk_ok", 32'(crc_ok), 32'd1);
    chk("chk_residue", 32'(crc), 32'd0);
    take_result();

    load_std();
    frm.push_back(FCS0); frm.push_back(FCS1 ^ 8'h01);
    send_frame(1'b1);
    chk("chk_bad_ok", 32'(crc_ok), 32'd0);
    chk("chk_bad_len", 32'(len_error), 32'd0);
    take_result();

    // Length boundaries.
    load_n(4);
    send_frame(1'b0);
    chk("short_len_error", 32'(len_error), 32'd1);
    chk("short_crc", 32'(crc), 32'd0);
    take_result();

    load_n(5);
    send_frame(1'b0);
    chk("min_len_error", 32'(len_error), 32'd0);
    chk("min_crc", 32'(crc), 32'(crc_model()));
    take_result();

    load_n(127);
    send_frame(1'b0);
    chk("max_len_error", 32'(len_error), 32'd0);
    chk("max_crc", 32'(crc), 32'(crc_model()));
    take_result();

    load_n(130);
    send_frame(1'b0);
    chk("over_len_error", 32'(len_error), 32'd1);
    chk("over_crc", 32'(crc), 32'd0);
    chk("over_cnt_sat", 32'(dut.cnt_q), 32'd128);
    take_result();

    // clr on the third beat drops that beat and aborts the frame.
    frm = {8'h31, 8'h32};
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = frm[i]; s_last = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1; s_data = 8'h33; clr = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; clr = 1'b0;
    chk("clr_res_valid", 32'(res_valid), 32'd0);
    chk("clr_s_ready", 32'(s_ready), 32'd1);
    load_std();
    send_frame(1'b0);
    chk("after_clr_crc", 32'(crc), 32'(STD_CRC));
    take_result();

    // Async reset while holding a result, then mid-frame.
    load_std();
    frm.push_back(FCS0); frm.push_back(FCS1);
    send_frame(1'b1);
    chk("pre_rst_ok", 32'(crc_ok), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_crc_ok", 32'(crc_ok), 32'd0);
    chk("arst_s_ready", 32'(s_ready), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 8'h55; s_last = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    load_std();
    send_frame(1'b0);
    chk("after_rst_crc", 32'(crc), 32'(STD_CRC));
    take_result();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
